// File: rtl/pwm_decode.sv
// rtl/pwm_decode.sv - ramp-compare PWM line decoder
//
// Purpose:
//   Recovers a WIDTH-bit value from a single-bit ramp-compare PWM line.
//   The encoder holds the line high while data >= ramp. The ramp steps
//   0..FRAME_LEN-1, one step per clock, so each frame is high for data+1
//   clocks. The decoder locks onto the rising edge that starts a frame.
//   It counts the high samples over one frame and emits count-1.
//
// Ports:
//   CLK100MHZ   in   1      system clock; all logic is clocked on the rising edge
//   reset       in   1      synchronous, active-high
//   start       in   1      enable; low forces IDLE and discards any partial frame
//   pwm_in      in   1      encoded line, already synchronous to CLK100MHZ
//   data_out    out  WIDTH  last decoded value; holds between frames
//   data_valid  out  1      one-cycle pulse; data_out updates in the same cycle
//   frame_err   out  1      one-cycle pulse on a protocol violation
//   locked      out  1      high while the decoder is measuring frames

module pwm_decode #(
  parameter int WIDTH = 8
) (
  input  logic             CLK100MHZ,
  input  logic             reset,
  input  logic             start,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             frame_err,
  output logic             locked
);

  localparam int FRAME_LEN = 2 ** WIDTH;

  // Index of the final sample in a frame. The frame counter is WIDTH bits
  // wide, so it wraps from this value back to 0 with no extra logic.
  localparam logic [WIDTH-1:0] LAST_SAMPLE = WIDTH'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_MEASURE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] frame_cnt_q, frame_cnt_d;
  logic [WIDTH:0]   hi_cnt_q, hi_cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             locked_q;
  logic             prev_in_q;

  logic             rise;
  logic [WIDTH:0]   hi_total;
  logic [WIDTH:0]   hi_total_m1;

  // Edge detection uses the previous sample. That sample is captured in
  // every state, so the first cycle of ARMED already sees a valid history.
  assign rise        = pwm_in & ~prev_in_q;

  // High count including the current sample. hi_cnt reaches at most
  // FRAME_LEN, which is why it carries one extra bit.
  assign hi_total    = hi_cnt_q + (WIDTH+1)'(pwm_in);
  assign hi_total_m1 = hi_total - (WIDTH+1)'(1);

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    hi_cnt_d    = hi_cnt_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;

    if (!start) begin
      // Dropping the enable takes priority over every other condition.
      // Any partial frame is discarded silently.
      state_d     = S_IDLE;
      frame_cnt_d = '0;
      hi_cnt_d    = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_ARMED;
        end

        S_ARMED: begin
          // A line held constantly high never produces this edge. An all-ones
          // stream therefore needs one low-to-high transition before it can lock.
          if (rise) begin
            frame_cnt_d = WIDTH'(1);
            hi_cnt_d    = (WIDTH+1)'(1);
            state_d     = S_MEASURE;
          end
        end

        S_MEASURE: begin
          if (frame_cnt_q == '0) begin
            // Every frame begins with a high sample. An all-ones previous frame
            // gives no edge here, so only the level is checked.
            if (!pwm_in) begin
              err_d       = 1'b1;
              state_d     = S_ARMED;
              hi_cnt_d    = '0;
            end else begin
              hi_cnt_d    = (WIDTH+1)'(1);
              frame_cnt_d = WIDTH'(1);
            end
          end else if (rise) begin
            // A second pulse inside one frame means the line and our frame
            // alignment disagree. Drop the frame and wait for a fresh edge.
            // The next cycle sees prev_in=1, so this edge is not reused.
            err_d       = 1'b1;
            state_d     = S_ARMED;
            frame_cnt_d = '0;
            hi_cnt_d    = '0;
          end else if (frame_cnt_q == LAST_SAMPLE) begin
            data_d      = hi_total_m1[WIDTH-1:0];
            valid_d     = 1'b1;
            frame_cnt_d = '0;
            hi_cnt_d    = '0;
          end else begin
            hi_cnt_d    = hi_total;
            frame_cnt_d = frame_cnt_q + WIDTH'(1);
          end
        end

        default: begin
          state_d     = S_IDLE;
          frame_cnt_d = '0;
          hi_cnt_d    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state_q     <= S_IDLE;
      frame_cnt_q <= '0;
      hi_cnt_q    <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      locked_q    <= 1'b0;
      prev_in_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      hi_cnt_q    <= hi_cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      // Registered from the next state, so locked always mirrors the state register.
      locked_q    <= (state_d == S_MEASURE);
      prev_in_q   <= pwm_in;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = err_q;
  assign locked     = locked_q;

endmodule
